// File: rtl/v_loadunit_pkg.sv
// Shared definitions for the vector load/store unit.
//   - VLSU opcodes (store and load variants)
//   - load-unit FSM state type
//   - beat-count helpers derived from SEW and LMUL
package v_loadunit_pkg;

   localparam int VLEN  = 128;        // bits per vector register
   localparam int IMG_W = 4 * VLEN;   // register-group image (LMUL up to 4)

   typedef enum logic [3:0] {
      VLSU_NOP    = 4'h0,
      VLSU_VSE8   = 4'h1,
      VLSU_VSE16  = 4'h2,
      VLSU_VSE32  = 4'h3,
      VLSU_VSSE8  = 4'h4,
      VLSU_VSSE16 = 4'h5,
      VLSU_VSSE32 = 4'h6,
      VLSU_VLE8   = 4'h8,
      VLSU_VLE16  = 4'h9,
      VLSU_VLE32  = 4'hA,
      VLSU_VLSE8  = 4'hB,
      VLSU_VLSE16 = 4'hC,
      VLSU_VLSE32 = 4'hD
   } vlsu_op_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } vld_state_t;

   // Four banks deliver one element each per beat, so beats/reg = (VLEN/SEW)/4.
   function automatic logic [4:0] beats_per_reg(input logic [2:0] vsew);
      case (vsew)
         3'b000:  return 5'd4;
         3'b001:  return 5'd2;
         default: return 5'd1;
      endcase
   endfunction

   // Total beats for the register group; unsupported LMUL codes mean one register.
   function automatic logic [4:0] num_beats(input logic [2:0] vsew, input logic [2:0] lmul);
      case (lmul)
         3'b001:  return beats_per_reg(vsew) << 1;
         3'b010:  return beats_per_reg(vsew) << 2;
         default: return beats_per_reg(vsew);
      endcase
   endfunction

   // Compact element-width code: 0=8b, 1=16b, 2=32b (unsupported codes fall to 32b).
   function automatic logic [1:0] sew_code(input logic [2:0] vsew);
      case (vsew)
         3'b000:  return 2'd0;
         3'b001:  return 2'd1;
         default: return 2'd2;
      endcase
   endfunction

   function automatic logic is_load_op(input logic [3:0] op);
      case (op)
         VLSU_VLE8, VLSU_VLE16, VLSU_VLE32,
         VLSU_VLSE8, VLSU_VLSE16, VLSU_VLSE32: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

   function automatic logic is_strided_op(input logic [3:0] op);
      case (op)
         VLSU_VLSE8, VLSU_VLSE16, VLSU_VLSE32: return 1'b1;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/v_loadunit_if.sv
// Request / bank / result bundle of the vector load unit.
//   master: requester + memory side (drives request fields and bank read data)
//   slave : the load unit (drives bank addresses, rd_en, data_out, busy, done)
interface v_loadunit_if #(
   parameter int ADDR_W = 14,
   parameter int WORD_W = 32
);
   logic                           start;
   logic [3:0]                     load_op;
   logic [2:0]                     lmul;
   logic [2:0]                     vsew;
   logic [4:0]                     stride;
   logic [ADDR_W-1:0]              address;
   logic [WORD_W-1:0]              data_in0;
   logic [WORD_W-1:0]              data_in1;
   logic [WORD_W-1:0]              data_in2;
   logic [WORD_W-1:0]              data_in3;
   logic [ADDR_W-1:0]              data_addr0;
   logic [ADDR_W-1:0]              data_addr1;
   logic [ADDR_W-1:0]              data_addr2;
   logic [ADDR_W-1:0]              data_addr3;
   logic                           rd_en;
   logic [v_loadunit_pkg::IMG_W-1:0] data_out;
   logic                           busy;
   logic                           done;

   modport master (
      output start, load_op, lmul, vsew, stride, address,
      output data_in0, data_in1, data_in2, data_in3,
      input  data_addr0, data_addr1, data_addr2, data_addr3,
      input  rd_en, data_out, busy, done
   );

   modport slave (
      input  start, load_op, lmul, vsew, stride, address,
      input  data_in0, data_in1, data_in2, data_in3,
      output data_addr0, data_addr1, data_addr2, data_addr3,
      output rd_en, data_out, busy, done
   );
endinterface

// File: rtl/v_loadunit_ld_addrgen.sv
// Bank address generator for the vector load unit.
//   load      : capture base address and step (1 for unit stride, stride otherwise)
//   adv       : move to the next beat (base += 4*step)
//   addr0..3  : registered per-bank addresses base_k + j*step, wrapping mod 2^ADDR_W
module v_loadunit_ld_addrgen #(
   parameter int ADDR_W = 14
) (
   input  logic              clk,
   input  logic              nrst,
   input  logic              load,
   input  logic              adv,
   input  logic [ADDR_W-1:0] base_in,
   input  logic              strided_in,
   input  logic [4:0]        stride_in,
   output logic [ADDR_W-1:0] addr0,
   output logic [ADDR_W-1:0] addr1,
   output logic [ADDR_W-1:0] addr2,
   output logic [ADDR_W-1:0] addr3
);

   logic [ADDR_W-1:0] step_in;
   logic [ADDR_W-1:0] step_q, step_d;
   logic [ADDR_W-1:0] addr_q [4];
   logic [ADDR_W-1:0] addr_d [4];

   assign step_in = strided_in ? ADDR_W'(stride_in) : ADDR_W'(1);

   always_comb begin
      step_d = step_q;
      for (int j = 0; j < 4; j++) addr_d[j] = addr_q[j];
      if (load) begin
         step_d    = step_in;
         addr_d[0] = base_in;
         addr_d[1] = base_in + step_in;
         addr_d[2] = base_in + (step_in << 1);
         addr_d[3] = base_in + (step_in << 1) + step_in;
      end else if (adv) begin
         // Every bank moves by the span of one whole beat.
         for (int j = 0; j < 4; j++) addr_d[j] = addr_q[j] + (step_q << 2);
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         step_q <= '0;
         for (int j = 0; j < 4; j++) addr_q[j] <= '0;
      end else begin
         step_q <= step_d;
         for (int j = 0; j < 4; j++) addr_q[j] <= addr_d[j];
      end
   end

   assign addr0 = addr_q[0];
   assign addr1 = addr_q[1];
   assign addr2 = addr_q[2];
   assign addr3 = addr_q[3];

endmodule

// File: rtl/v_loadunit.sv
// Vector load data unit.
// Reads one element per bank per beat from four data-memory banks (unit-stride
// or strided) and packs them into a 4*VLEN-bit register-group image.
// Ports:
//   clk, nrst : clock (rising edge), asynchronous active-low reset
//   bus       : v_loadunit_if.slave -- request fields, bank read data in,
//               bank addresses / rd_en / data_out / busy / done out
module v_loadunit
   import v_loadunit_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int WORD_W = 32
) (
   input  logic         clk,
   input  logic         nrst,
   v_loadunit_if.slave  bus
);

   vld_state_t        state_q, state_d;
   logic [1:0]        sew_q, sew_d;
   logic [4:0]        nbeats_q, nbeats_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              rd_en_q, rd_en_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              cap_vld_q, cap_vld_d;
   logic [3:0]        cap_beat_q, cap_beat_d;
   logic [IMG_W-1:0]  data_out_q, data_out_d;

   logic              accept;
   logic              last_beat;
   logic [WORD_W-1:0] din [4];

   assign din[0] = bus.data_in0;
   assign din[1] = bus.data_in1;
   assign din[2] = bus.data_in2;
   assign din[3] = bus.data_in3;

   assign accept    = bus.start && (state_q == IDLE) && is_load_op(bus.load_op);
   assign last_beat = ({1'b0, cnt_q} == (nbeats_q - 5'd1));

   always_comb begin
      state_d    = state_q;
      sew_d      = sew_q;
      nbeats_d   = nbeats_q;
      cnt_d      = cnt_q;
      rd_en_d    = rd_en_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      // Bank data lags its read by one cycle, so capture follows issue.
      cap_vld_d  = rd_en_q;
      cap_beat_d = cnt_q;
      data_out_d = data_out_q;

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = RUN;
               sew_d    = sew_code(bus.vsew);
               nbeats_d = num_beats(bus.vsew, bus.lmul);
               cnt_d    = 4'd0;
               rd_en_d  = 1'b1;
               busy_d   = 1'b1;
            end
         end
         RUN: begin
            if (last_beat) begin
               state_d = DRAIN;
               rd_en_d = 1'b0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         DRAIN: begin
            state_d = DONE;
            done_d  = 1'b1;
         end
         DONE: begin
            state_d = IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = IDLE;
      endcase

      if (accept) begin
         data_out_d = '0;
      end else if (cap_vld_q) begin
         // Element index is beat*4 + bank; the bit offset is that index times SEW.
         for (int j = 0; j < 4; j++) begin
            case (sew_q)
               2'd0:    data_out_d[{cap_beat_q, 2'(j), 3'b000} +: 8]       = din[j][7:0];
               2'd1:    data_out_d[{cap_beat_q[2:0], 2'(j), 4'b0000} +: 16] = din[j][15:0];
               default: data_out_d[{cap_beat_q[1:0], 2'(j), 5'b00000} +: 32] = din[j][31:0];
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= IDLE;
         sew_q      <= 2'd0;
         nbeats_q   <= 5'd1;
         cnt_q      <= 4'd0;
         rd_en_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         cap_vld_q  <= 1'b0;
         cap_beat_q <= 4'd0;
         data_out_q <= '0;
      end else begin
         state_q    <= state_d;
         sew_q      <= sew_d;
         nbeats_q   <= nbeats_d;
         cnt_q      <= cnt_d;
         rd_en_q    <= rd_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         cap_vld_q  <= cap_vld_d;
         cap_beat_q <= cap_beat_d;
         data_out_q <= data_out_d;
      end
   end

   v_loadunit_ld_addrgen #(.ADDR_W(ADDR_W)) u_addrgen (
      .clk        (clk),
      .nrst       (nrst),
      .load       (accept),
      .adv        (rd_en_q),
      .base_in    (bus.address),
      .strided_in (is_strided_op(bus.load_op)),
      .stride_in  (bus.stride),
      .addr0      (bus.data_addr0),
      .addr1      (bus.data_addr1),
      .addr2      (bus.data_addr2),
      .addr3      (bus.data_addr3)
   );

   assign bus.rd_en    = rd_en_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_v_loadunit.sv
// Scoreboard bench for v_loadunit: stimulus pushes expected images and bank
// address beats; independent monitors pop and compare on rd_en and done.
module tb_v_loadunit;
   import v_loadunit_pkg::*;

   logic clk = 1'b0;
   logic nrst;
   always #5 clk = ~clk;

   v_loadunit_if #(.ADDR_W(14), .WORD_W(32)) bus ();
   v_loadunit #(.ADDR_W(14), .WORD_W(32)) dut (.clk(clk), .nrst(nrst), .bus(bus));

   typedef logic [3:0][13:0] beat_t;
   typedef struct {
      logic [511:0] img;
      int           done_cyc;
      string        name;
   } exp_t;

   exp_t  sb [$];
   beat_t aq [$];
   int    errors = 0;
   int    checks = 0;
   int    cyc    = 0;
   int    mem_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem(input logic [13:0] a);
      if (mem_mode == 0) return 32'(a) + 32'h100;
      return {16'hBEEF, 2'b00, a};
   endfunction

   task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Bank model + address monitor: data for a read appears one cycle later.
   logic [31:0] pend [4];
   initial begin
      for (int j = 0; j < 4; j++) pend[j] = 32'hDEAD0000;
      forever begin
         @(negedge clk);
         bus.data_in0 = pend[0];
         bus.data_in1 = pend[1];
         bus.data_in2 = pend[2];
         bus.data_in3 = pend[3];
         if (bus.rd_en === 1'b1) begin
            pend[0] = mem(bus.data_addr0);
            pend[1] = mem(bus.data_addr1);
            pend[2] = mem(bus.data_addr2);
            pend[3] = mem(bus.data_addr3);
            if (aq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_rd_en: got rd_en=1 at cycle %0d required no read", cyc);
            end else begin
               beat_t b;
               b = aq.pop_front();
               chk("bank_addrs", {456'b0, bus.data_addr3, bus.data_addr2, bus.data_addr1, bus.data_addr0},
                   {456'b0, b[3], b[2], b[1], b[0]});
            end
         end else begin
            for (int j = 0; j < 4; j++) pend[j] = 32'hDEAD0000 + 32'(j);
         end
      end
   end

   // Completion monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 at cycle %0d required none", cyc);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.name, "_data"}, bus.data_out, e.img);
               chk({e.name, "_done_cycle"}, 512'(cyc), 512'(e.done_cyc));
               chk({e.name, "_busy_at_done"}, 512'(bus.busy), 512'd1);
            end
         end
      end
   end

   task automatic issue(input logic [3:0] op, input logic [2:0] lm, input logic [2:0] vs,
                        input logic [4:0] st, input logic [13:0] ad, input string nm,
                        input bit expect_done, output logic [511:0] img);
      int nb, sew, a;
      logic [13:0] step, base, ea;
      logic [31:0] d;
      beat_t bt;
      exp_t e;
      nb  = ((vs == 3'b000) ? 4 : (vs == 3'b001) ? 2 : 1) *
            ((lm == 3'b001) ? 2 : (lm == 3'b010) ? 4 : 1);
      sew = (vs == 3'b000) ? 8 : (vs == 3'b001) ? 16 : 32;
      step = (op == VLSU_VLSE8 || op == VLSU_VLSE16 || op == VLSU_VLSE32) ? 14'(st) : 14'd1;
      @(negedge clk);
      bus.start = 1'b1; bus.load_op = op; bus.lmul = lm; bus.vsew = vs;
      bus.stride = st; bus.address = ad;
      @(posedge clk);
      #1;
      a    = cyc;
      img  = '0;
      base = ad;
      for (int k = 0; k < nb; k++) begin
         for (int j = 0; j < 4; j++) begin
            ea    = base + 14'(j) * step;
            bt[j] = ea;
            d     = mem(ea);
            for (int b = 0; b < sew; b++) img[(k * 4 + j) * sew + b] = d[b];
         end
         aq.push_back(bt);
         base = base + 14'd4 * step;
      end
      if (expect_done) begin
         e.img = img; e.done_cyc = a + nb + 1; e.name = nm;
         sb.push_back(e);
      end
      @(negedge clk);
      // Scramble the request fields: the unit must work from its latched copy.
      bus.start = 1'b0; bus.address = 14'h2AAA; bus.stride = 5'd17;
      bus.vsew = 3'b001; bus.lmul = 3'b010; bus.load_op = VLSU_VLSE8;
   endtask

   task automatic wait_done(input string nm);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.done !== 1'b1 && n < 60);
      if (bus.done !== 1'b1) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no done within %0d cycles required done", nm, n);
      end
   endtask

   logic [511:0] img, held;

   initial begin
      nrst = 1'b0;
      bus.start = 1'b0; bus.load_op = VLSU_NOP; bus.lmul = 3'b000; bus.vsew = 3'b000;
      bus.stride = 5'd0; bus.address = 14'd0;
      bus.data_in0 = '0; bus.data_in1 = '0; bus.data_in2 = '0; bus.data_in3 = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_rd_en", 512'(bus.rd_en), 512'd0);
      chk("rst_busy",  512'(bus.busy),  512'd0);
      chk("rst_done",  512'(bus.done),  512'd0);
      chk("rst_addrs", {456'b0, bus.data_addr3, bus.data_addr2, bus.data_addr1, bus.data_addr0}, 512'd0);
      chk("rst_data_out", bus.data_out, 512'd0);
      @(negedge clk);
      nrst = 1'b1;

      // 1 beat, hand value: banks return addr+0x100.
      mem_mode = 0;
      issue(VLSU_VLE32, 3'b000, 3'b010, 5'd0, 14'h010, "vle32", 1'b1, img);
      wait_done("vle32");
      chk("vle32_hand", {384'b0, bus.data_out[127:0]},
          {384'b0, 128'h00000113_00000112_00000111_00000110});

      mem_mode = 1;
      issue(VLSU_VLE8, 3'b001, 3'b000, 5'd0, 14'h000, "vle8", 1'b1, img);
      wait_done("vle8");
      chk("vle8_upper_zero", {256'b0, bus.data_out[511:256]}, 512'd0);
      chk("vle8_hand", {256'b0, bus.data_out[255:0]},
          {256'b0, 256'h1F1E1D1C_1B1A1918_17161514_13121110_0F0E0D0C_0B0A0908_07060504_03020100});

      issue(VLSU_VLSE16, 3'b000, 3'b001, 5'd3, 14'h3FF0, "vlse16", 1'b1, img);
      wait_done("vlse16");
      chk("vlse16_elem5", {496'b0, bus.data_out[5*16 +: 16]}, {496'b0, 16'h3FFF});
      chk("vlse16_elem6", {496'b0, bus.data_out[6*16 +: 16]}, {496'b0, 16'h0002});

      issue(VLSU_VLSE32, 3'b010, 3'b010, 5'd0, 14'h000, "vlse32_s0", 1'b1, held);
      wait_done("vlse32_s0");
      chk("vlse32_s0_hand", {384'b0, bus.data_out[127:0]},
          {384'b0, {4{32'hBEEF0000}}});
      repeat (3) @(negedge clk);
      chk("data_out_held", bus.data_out, held);

      // Store opcode must not start the load unit.
      @(negedge clk);
      bus.start = 1'b1; bus.load_op = VLSU_VSE32; bus.lmul = 3'b000; bus.vsew = 3'b010;
      bus.address = 14'h055;
      @(posedge clk);
      #1;
      chk("store_op_busy",  512'(bus.busy),  512'd0);
      chk("store_op_rd_en", 512'(bus.rd_en), 512'd0);
      @(negedge clk);
      bus.start = 1'b0;
      chk("store_op_data_held", bus.data_out, held);

      // Start pulsed while running is ignored.
      issue(VLSU_VLE8, 3'b010, 3'b000, 5'd0, 14'h100, "vle8_run", 1'b1, img);
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.load_op = VLSU_VLE16; bus.address = 14'h200;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("vle8_run");

      // Reset during a 16-beat load.
      issue(VLSU_VLE8, 3'b010, 3'b000, 5'd0, 14'h040, "rst_mid", 1'b0, img);
      repeat (2) @(negedge clk);
      nrst = 1'b0;
      #1;
      chk("midrst_rd_en", 512'(bus.rd_en), 512'd0);
      chk("midrst_busy",  512'(bus.busy),  512'd0);
      chk("midrst_data_out", bus.data_out, 512'd0);
      aq.delete();
      repeat (2) @(negedge clk);
      nrst = 1'b1;
      repeat (4) @(negedge clk);
      chk("postrst_data_out", bus.data_out, 512'd0);
      chk("postrst_busy", 512'(bus.busy), 512'd0);

      issue(VLSU_VLE16, 3'b001, 3'b001, 5'd0, 14'h0123, "after_rst", 1'b1, img);
      wait_done("after_rst");

      repeat (3) @(negedge clk);
      chk("sb_empty", 512'(sb.size()), 512'd0);
      chk("aq_empty", 512'(aq.size()), 512'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
